// File: rtl/motor_speed_sequencer_pkg.sv
// motor_speed_sequencer_pkg
// Shared types and constants for the motor speed sequencer slice.
//   state_t        : 2-bit sequencer state
//   c_Speed_Width  : width of speed commands / applied speed
//   c_Range_Width  : width of the PWM control range
//   c_Stop_Code    : command byte that requests a stop
package motor_speed_sequencer_pkg;

  localparam int c_Speed_Width = 8;
  localparam int c_Range_Width = 24;

  localparam logic [c_Speed_Width-1:0] c_Stop_Code = 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2,
    ST_HOLD      = 2'd3
  } state_t;

endpackage

// File: rtl/motor_speed_sequencer_tick_gen.sv
// tick_gen
// Free-running divide-by-g_Div strobe generator. The counter wraps at
// g_Div-1 and o_Tick is high for exactly that one cycle.
// Ports:
//   i_Clk    : clock
//   i_Rst_L  : asynchronous active-low reset (counter to 0)
//   o_Tick   : one-cycle strobe every g_Div clocks
module tick_gen #(
  parameter int g_Div = 100000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  output logic o_Tick
);

  localparam int c_W = (g_Div > 1) ? $clog2(g_Div) : 1;
  localparam logic [c_W-1:0] c_Last = c_W'(g_Div - 1);

  logic [c_W-1:0] cnt_q;
  logic [c_W-1:0] cnt_d;

  assign o_Tick = (cnt_q == c_Last);
  assign cnt_d  = o_Tick ? '0 : cnt_q + c_W'(1);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/motor_speed_sequencer.sv
// motor_speed_sequencer
// Validates speed bytes from the UART receiver and slews the applied speed
// toward the commanded target in fixed steps, one step per ramp tick.
// Optional build macro: MOTOR_WATCHDOG_EN (forced stop on command silence).
// Ports:
//   i_Clk            : system clock
//   i_Rst_L          : asynchronous active-low reset
//   i_RX_DV          : one-cycle byte-valid strobe from UART_RX
//   i_RX_Byte        : received byte
//   o_Control_Range  : registered current speed * g_Multiply_By
//   o_Target         : latched commanded speed
//   o_Current        : applied speed
//   o_Busy           : current differs from target
//   o_Cmd_Error      : one-cycle pulse after a rejected byte
//   o_Timeout        : sticky watchdog-stop flag (0 without the watchdog)
//
// state        | meaning
// ST_IDLE      | current = 0 and target = 0, motor stopped
// ST_RAMP_UP   | target above current, step up on each tick
// ST_RAMP_DOWN | target below current, step down on each tick
// ST_HOLD      | current = target > 0, steady speed
module motor_speed_sequencer
  import motor_speed_sequencer_pkg::*;
#(
  parameter int g_Min_Byte     = 10,
  parameter int g_Max_Byte     = 100,
  parameter int g_Multiply_By  = 33003,
  parameter int g_Step_Clks    = 100000,
  parameter int g_Step_Size    = 1,
  parameter int g_Timeout_Clks = 100000000
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic                     i_RX_DV,
  input  logic [c_Speed_Width-1:0] i_RX_Byte,
  output logic [c_Range_Width-1:0] o_Control_Range,
  output logic [c_Speed_Width-1:0] o_Target,
  output logic [c_Speed_Width-1:0] o_Current,
  output logic                     o_Busy,
  output logic                     o_Cmd_Error,
  output logic                     o_Timeout
);

  localparam logic [c_Speed_Width-1:0] c_Min  = c_Speed_Width'(g_Min_Byte);
  localparam logic [c_Speed_Width-1:0] c_Max  = c_Speed_Width'(g_Max_Byte);
  localparam logic [c_Speed_Width:0]   c_Step = (c_Speed_Width+1)'(g_Step_Size);
  // Below this speed a step toward zero would land in the dead band, so a
  // stop drops straight to 0.
  localparam logic [c_Speed_Width:0]   c_Stop_Thr =
    (c_Speed_Width+1)'(g_Min_Byte + g_Step_Size - 1);
  localparam logic [c_Range_Width-1:0] c_Mult = c_Range_Width'(g_Multiply_By);

  state_t                   state_q, state_d;
  logic [c_Speed_Width-1:0] target_q, target_d;
  logic [c_Speed_Width-1:0] current_q, current_d;
  logic [c_Range_Width-1:0] range_q, range_d;
  logic                     err_q, err_d;
  logic                     tick;
  logic                     cmd_valid;

  logic [c_Speed_Width:0]   cur9;
  logic [c_Speed_Width:0]   tgt9;
  logic [c_Speed_Width:0]   up_sum;
  logic [c_Speed_Width:0]   dn_floor;

  tick_gen #(
    .g_Div (g_Step_Clks)
  ) u_tick_gen (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .o_Tick  (tick)
  );

  assign cmd_valid = (i_RX_Byte == c_Stop_Code) ||
                     ((i_RX_Byte >= c_Min) && (i_RX_Byte <= c_Max));

  // Command decode; the watchdog below may override target_d.
`ifdef MOTOR_WATCHDOG_EN
  localparam int c_Wd_W = (g_Timeout_Clks > 1) ? $clog2(g_Timeout_Clks) : 1;
  localparam logic [c_Wd_W-1:0] c_Wd_Last = c_Wd_W'(g_Timeout_Clks - 1);

  logic [c_Wd_W-1:0] wd_q, wd_d;
  logic              timeout_q, timeout_d;

  always_comb begin
    target_d  = target_q;
    err_d     = 1'b0;
    timeout_d = timeout_q;
    wd_d      = wd_q;
    if (i_RX_DV) begin
      // Any received byte, valid or not, proves the link is alive, and it
      // takes priority over an expiry in the same cycle.
      wd_d = '0;
      if (cmd_valid) begin
        target_d  = i_RX_Byte;
        timeout_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if ((current_q != '0) || (target_q != '0)) begin
      if (wd_q == c_Wd_Last) begin
        wd_d      = '0;
        target_d  = c_Stop_Code;
        timeout_d = 1'b1;
      end else begin
        wd_d = wd_q + c_Wd_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_Timeout = timeout_q;
`else
  always_comb begin
    target_d = target_q;
    err_d    = 1'b0;
    if (i_RX_DV) begin
      if (cmd_valid) begin
        target_d = i_RX_Byte;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign o_Timeout = 1'b0;
`endif

  // State is derived every cycle from the registers, so a reversed command
  // changes direction on the very next tick.
  always_comb begin
    if (current_q == target_q) begin
      state_d = (current_q == '0) ? ST_IDLE : ST_HOLD;
    end else if (target_q > current_q) begin
      state_d = ST_RAMP_UP;
    end else begin
      state_d = ST_RAMP_DOWN;
    end
  end

  // 9-bit step arithmetic: no wrap, and results clamp to the target.
  assign cur9     = {1'b0, current_q};
  assign tgt9     = {1'b0, target_q};
  assign up_sum   = cur9 + c_Step;
  assign dn_floor = tgt9 + c_Step;

  always_comb begin
    current_d = current_q;
    if (tick) begin
      case (state_d)
        ST_RAMP_UP: begin
          if (current_q == '0) begin
            current_d = c_Min;
          end else if (up_sum >= tgt9) begin
            current_d = target_q;
          end else begin
            current_d = up_sum[c_Speed_Width-1:0];
          end
        end
        ST_RAMP_DOWN: begin
          if ((target_q == '0) && (cur9 <= c_Stop_Thr)) begin
            current_d = '0;
          end else if (cur9 <= dn_floor) begin
            current_d = target_q;
          end else begin
            current_d = current_q - c_Step[c_Speed_Width-1:0];
          end
        end
        default: current_d = current_q;
      endcase
    end
  end

  assign range_d = {{(c_Range_Width-c_Speed_Width){1'b0}}, current_q} * c_Mult;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      target_q  <= '0;
      current_q <= '0;
      range_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      current_q <= current_d;
      range_q   <= range_d;
      err_q     <= err_d;
    end
  end

  assign o_Control_Range = range_q;
  assign o_Target        = target_q;
  assign o_Current       = current_q;
  assign o_Busy          = (current_q != target_q);
  assign o_Cmd_Error     = err_q;

endmodule

// File: tb/tb_motor_speed_sequencer.sv
// tb_motor_speed_sequencer
// Directed bench for motor_speed_sequencer with a 4-clock ramp tick and a
// 64-clock command-silence limit. Watchdog checks compile in only when
// MOTOR_WATCHDOG_EN is defined.
module tb_motor_speed_sequencer;

  logic        clk;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic [23:0] ctrl_range;
  logic [7:0]  target;
  logic [7:0]  current;
  logic        busy;
  logic        cmd_err;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;

  motor_speed_sequencer #(
    .g_Min_Byte     (10),
    .g_Max_Byte     (100),
    .g_Multiply_By  (33003),
    .g_Step_Clks    (4),
    .g_Step_Size    (1),
    .g_Timeout_Clks (64)
  ) dut (
    .i_Clk           (clk),
    .i_Rst_L         (rst_n),
    .i_RX_DV         (rx_dv),
    .i_RX_Byte       (rx_byte),
    .o_Control_Range (ctrl_range),
    .o_Target        (target),
    .o_Current       (current),
    .o_Busy          (busy),
    .o_Cmd_Error     (cmd_err),
    .o_Timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  // Waits (bounded) for o_Current to move, then checks the new value.
  task automatic step_to(input string tag, input logic [7:0] exp);
    logic [7:0] prev;
    int n;
    prev = current;
    n = 0;
    while (current == prev && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {24'd0, current}, {24'd0, exp});
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_dv   = 1'b0;
    rx_byte = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_current", {24'd0, current}, 32'd0);
    chk("rst_target", {24'd0, target}, 32'd0);
    chk("rst_range", {8'd0, ctrl_range}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    rst_n = 1'b1;

    // Rejected bytes: one-cycle error pulse, target untouched.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rx_dv   = 1'b1;
      rx_byte = (i == 0) ? 8'd5 : 8'd101;
      @(negedge clk);
      rx_dv = 1'b0;
      chk("err_pulse", {31'd0, cmd_err}, 32'd1);
      @(negedge clk);
      chk("err_one_cycle", {31'd0, cmd_err}, 32'd0);
      chk("err_target", {24'd0, target}, 32'd0);
    end

    // Ramp up to 50, jumping past the dead band on the first tick.
    send_byte(8'd50);
    chk("cmd50_target", {24'd0, target}, 32'd50);
    chk("cmd50_noerr", {31'd0, cmd_err}, 32'd0);
    chk("cmd50_busy", {31'd0, busy}, 32'd1);
    step_to("up_first", 8'd10);
    for (int v = 11; v <= 50; v++) step_to("up_step", 8'(v));
    chk("range_lag", {8'd0, ctrl_range}, 32'd1617147);
    chk("hold_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("range_50", {8'd0, ctrl_range}, 32'd1650150);

    // Ramp down to 20, no undershoot.
    send_byte(8'd20);
    for (int v = 49; v >= 20; v--) step_to("down_step", 8'(v));
    repeat (12) @(negedge clk);
    chk("down_hold", {24'd0, current}, 32'd20);
    chk("down_busy", {31'd0, busy}, 32'd0);

    // Down to 12, then stop: 12 -> 11 -> 10 -> 0.
    send_byte(8'd12);
    for (int v = 19; v >= 12; v--) step_to("to12", 8'(v));
    send_byte(8'd0);
    step_to("stop_11", 8'd11);
    step_to("stop_10", 8'd10);
    step_to("stop_0", 8'd0);
    repeat (2) @(negedge clk);
    chk("stop_range", {8'd0, ctrl_range}, 32'd0);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_target", {24'd0, target}, 32'd0);

    // Reversal mid-ramp: heading to 80, at 30 command 15.
    send_byte(8'd80);
    step_to("rev_first", 8'd10);
    for (int v = 11; v <= 30; v++) step_to("rev_up", 8'(v));
    send_byte(8'd15);
    for (int v = 29; v >= 15; v--) step_to("rev_down", 8'(v));
    repeat (8) @(negedge clk);
    chk("rev_hold", {24'd0, current}, 32'd15);

    // Asynchronous reset mid-ramp.
    send_byte(8'd50);
    step_to("mid_16", 8'd16);
    step_to("mid_17", 8'd17);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_current", {24'd0, current}, 32'd0);
    chk("async_target", {24'd0, target}, 32'd0);
    chk("async_range", {8'd0, ctrl_range}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MOTOR_WATCHDOG_EN
    begin
      int guard;
      // Keep the link alive while ramping to 40.
      send_byte(8'd40);
      guard = 0;
      while (current != 8'd40 && guard < 400) begin
        @(negedge clk);
        guard++;
        if (guard % 16 == 0) send_byte(8'd40);
      end
      chk("wd_at40", {24'd0, current}, 32'd40);
      send_byte(8'd40);
      repeat (63) @(negedge clk);
      chk("wd_not_yet", {31'd0, timeout}, 32'd0);
      @(negedge clk);
      chk("wd_fired", {31'd0, timeout}, 32'd1);
      chk("wd_target0", {24'd0, target}, 32'd0);
      for (int v = 39; v >= 10; v--) step_to("wd_down", 8'(v));
      step_to("wd_zero", 8'd0);
      send_byte(8'd30);
      chk("wd_clear", {31'd0, timeout}, 32'd0);
      chk("wd_target30", {24'd0, target}, 32'd30);
      // Byte lands exactly in the expiry cycle.
      repeat (62) @(negedge clk);
      send_byte(8'd35);
      chk("wd_race_timeout", {31'd0, timeout}, 32'd0);
      chk("wd_race_target", {24'd0, target}, 32'd35);
    end
`else
    send_byte(8'd30);
    repeat (80) @(negedge clk);
    chk("no_wd_timeout", {31'd0, timeout}, 32'd0);
    chk("no_wd_target", {24'd0, target}, 32'd30);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
